axi_slave_arbiter: RTL and testbench
====================================

// Module: axi_slave_arbiter
// PURPOSE
//  Per-slave, per-direction (AW/W->B or AR->R) round-robin arbiter for the AXI4-Lite crossbar.
//  Arbitrates among masters whose address decodes to this slave (request = valid & match).
//  Holds the grant until the slave's response handshake completes, then rotates priority.
//  One instance per slave port per direction; its grant drives the crossbar request/response muxes.
// PARAMETERS
//  N_MASTERS      2     number of requesting masters (>=2)
//  TIMEOUT_CYCLES 1024  watchdog limit in cycles (used only with AXI_ARB_TIMEOUT_EN; >=2)
// PORTS
//  clk_i        in   1            clock; all logic on rising edge
//  rst_ni       in   1            reset, synchronous, active-low
//  req_i        in   N_MASTERS    per-master request (addr valid & decoder match for this slave)
//  addr_hs_i    in   1            address handshake at slave port (AxVALID & AxREADY)
//  resp_hs_i    in   1            response handshake at slave port (BVALID&BREADY / RVALID&RREADY)
//  grant_o      out  N_MASTERS    one-hot grant, registered
//  grant_idx_o  out  IDX_W        binary index of grant_o; IDX_W = $clog2(N_MASTERS)
//  busy_o       out  1            high in ARB_ADDR or ARB_RESP
//  timeout_o    out  1            1-cycle watchdog pulse (tied 0 without AXI_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state=ARB_IDLE, grant_o=0, grant_idx_o=0, busy_o=0, timeout_o=0, rr_ptr=0.
//  Reset mid-transaction: immediate abandon, same values; no response tracking survives.
//  States: ARB_IDLE -> ARB_ADDR -> ARB_RESP -> ARB_IDLE.
//  ARB_IDLE: if |req_i, pick first set req_i[k] scanning k = rr_ptr, rr_ptr+1, ... mod N_MASTERS;
//   grant_o/grant_idx_o registered -> visible 1 cycle after req_i seen; go ARB_ADDR.
//   If no req, stay; grant_o stays 0.
//  ARB_ADDR: grant held; on addr_hs_i go ARB_RESP. resp_hs_i here is ignored (protocol error, asserted).
//   req_i deassert of the granted master is illegal (AXI valid-stability); grant held regardless.
//  ARB_RESP: grant held; on resp_hs_i: grant_o<=0, rr_ptr<=(grant_idx+1) mod N_MASTERS, go ARB_IDLE.
//   addr_hs_i here is ignored (slave port gated by grant; asserted never).
//  Simultaneous events: addr_hs_i and resp_hs_i same cycle in ARB_ADDR -> only addr_hs_i acted on.
//  Throughput: one outstanding transaction per instance; min 1 idle cycle between grants
//   (grant n+1 appears 2 cycles after resp_hs_i of grant n, if requested).
//  Fairness: granted master becomes lowest priority; worst-case wait = N_MASTERS-1 transactions.
//  rr_ptr wrap: N_MASTERS-1 +1 -> 0; non-power-of-2 N_MASTERS handled by explicit compare, not bit truncation.
//  Requests from masters not granted are untouched (they stall upstream); no request queuing.
// CONFIGURATION
//  AXI_ARB_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering ARB_ADDR,
//   increments each cycle in ARB_ADDR/ARB_RESP; when it reaches TIMEOUT_CYCLES without the expected
//   handshake: timeout_o=1 for 1 cycle, grant_o<=0, rr_ptr advances as for normal completion, -> ARB_IDLE.
//   Handshake in the same cycle as expiry wins (no timeout pulse).
//  Undefined: no counter, timeout_o tied 0, grant held indefinitely.
// STRUCTURE
//  Package axi_xbar_pkg: typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_ADDR, ARB_RESP};
//   function idx_w(n) for index width; shared with decoder/mux instances.
//  Sub-module axi_rr_picker: combinational rotate-priority select (req, ptr -> onehot, idx, any).
//  Top: state register, grant/ptr registers, optional watchdog counter, SVA protocol checks.
// TESTING
//  1 Reset: drive req_i=2'b11, rst_ni=0 3 cycles -> grant_o=0, busy_o=0; release -> grant_o=2'b01 next cycle.
//  2 Rotation: N=3, req_i=3'b111 constant, complete 6 txns -> grant order 0,1,2,0,1,2; 1 idle cycle between.
//  3 Hold: grant master1, addr_hs_i pulse, delay resp_hs_i 20 cycles, req_i[0] high -> grant_o=2'b10
//    stable all 20 cycles; master0 granted 2 cycles after resp_hs_i.
//  4 Skip: N=4, rr_ptr=1, req_i=4'b1001 -> grant_idx_o=3; after completion req_i=4'b0001 -> grant 0.
//  5 Mid-op reset: assert rst_ni=0 in ARB_RESP -> next cycle grant_o=0, busy_o=0, rr_ptr=0.
//  6 Timeout (AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no resp_hs_i -> timeout_o pulse at count 8,
//    grant_o=0, next master granted; resp_hs_i at count 8 -> no pulse.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// Shared AXI4-Lite crossbar types: arbiter state encoding and index-width helper.
package axi_xbar_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping at N.
module axi_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Wrap by explicit compare so non-power-of-2 N never aliases onto a missing master.
    function automatic int wrap_idx(input int p, input int k);
        int c;
        c = p + k;
        return (c >= N) ? (c - N) : c;
    endfunction

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap_idx(int'(ptr), k)]) begin
                any                          = 1'b1;
                onehot[wrap_idx(int'(ptr), k)] = 1'b1;
                idx                          = IDX_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/axi_slave_arbiter.sv
// Per-slave, per-direction round-robin arbiter holding grant from address through response.
// Optional watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_slave_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = idx_w(N_MASTERS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic                 addr_hs_i,
    input  logic                 resp_hs_i,
    output logic [N_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d, pick_onehot;
    logic [IDX_W-1:0]     idx_q, idx_d, ptr_q, ptr_d, pick_idx;
    logic                 pick_any;
    logic                 timeout_q, timeout_d;
    logic                 expired;
    logic                 finish;

    axi_rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // One budget spans both address and response phases; saturates at the limit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (addr_hs_i) begin
                    state_d = ARB_RESP;
                end else if (expired) begin
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ARB_RESP: begin
                if (resp_hs_i) begin
                    finish = 1'b1;
                end else if (expired) begin
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
        // The master just served drops to lowest priority.
        if (finish) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
            ptr_d   = (idx_q == IDX_W'(N_MASTERS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q != ARB_IDLE);
    assign timeout_o   = timeout_q;

    a_params: assert property (@(posedge clk_i) (N_MASTERS >= 2) && (TIMEOUT_CYCLES >= 2));
    a_no_resp_in_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_ADDR) |-> !resp_hs_i);
    a_no_addr_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_RESP) |-> !addr_hs_i);
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_ADDR) |-> |(req_i & grant_q));
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(grant_q));

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// Directed bench for axi_slave_arbiter using N=2, N=3 (short watchdog) and N=4 instances.
module tb_axi_slave_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         passed = 0;

    logic [1:0] req2;
    logic       ahs2, rhs2;
    logic [1:0] g2;
    logic       gi2;
    logic       busy2, to2;

    logic [2:0] req3;
    logic       ahs3, rhs3;
    logic [2:0] g3;
    logic [1:0] gi3;
    logic       busy3, to3;

    logic [3:0] req4;
    logic       ahs4, rhs4;
    logic [3:0] g4;
    logic [1:0] gi4;
    logic       busy4, to4;

    always #5 clk = ~clk;

    axi_slave_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(1024)) u_arb2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .addr_hs_i(ahs2), .resp_hs_i(rhs2),
        .grant_o(g2), .grant_idx_o(gi2), .busy_o(busy2), .timeout_o(to2));

    axi_slave_arbiter #(.N_MASTERS(3), .TIMEOUT_CYCLES(8)) u_arb3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .addr_hs_i(ahs3), .resp_hs_i(rhs3),
        .grant_o(g3), .grant_idx_o(gi3), .busy_o(busy3), .timeout_o(to3));

    axi_slave_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(1024)) u_arb4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .addr_hs_i(ahs4), .resp_hs_i(rhs4),
        .grant_o(g4), .grant_idx_o(gi4), .busy_o(busy4), .timeout_o(to4));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req2  = 2'b11;
        repeat (3) cyc();
        checks++; if (g2 !== 2'b00) $display("FAIL reset_grant: got %b expected 00", g2); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy2); else passed++;
        checks++; if (gi2 !== 1'b0) $display("FAIL reset_idx: got %b expected 0", gi2); else passed++;
        checks++; if (to2 !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", to2); else passed++;
        rst_n = 1'b1;
        cyc();
        checks++; if (g2 !== 2'b01) $display("FAIL release_grant: got %b expected 01", g2); else passed++;
        checks++; if (busy2 !== 1'b1) $display("FAIL release_busy: got %b expected 1", busy2); else passed++;
        ahs2 = 1'b1; cyc(); ahs2 = 1'b0;
        req2 = 2'b00;
        rhs2 = 1'b1; cyc(); rhs2 = 1'b0;
        checks++; if (g2 !== 2'b00) $display("FAIL complete_grant: got %b expected 00", g2); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL complete_busy: got %b expected 0", busy2); else passed++;
    endtask

    task automatic test_hold();
        int bad;
        bad  = 0;
        req2 = 2'b11;
        cyc();
        checks++; if (g2 !== 2'b10) $display("FAIL hold_grant: got %b expected 10", g2); else passed++;
        checks++; if (gi2 !== 1'b1) $display("FAIL hold_idx: got %b expected 1", gi2); else passed++;
        ahs2 = 1'b1; cyc(); ahs2 = 1'b0;
        req2 = 2'b01;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (g2 !== 2'b10) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); else passed++;
        rhs2 = 1'b1; cyc(); rhs2 = 1'b0;
        checks++; if (g2 !== 2'b00) $display("FAIL hold_idle_gap: got %b expected 00", g2); else passed++;
        cyc();
        checks++; if (g2 !== 2'b01) $display("FAIL hold_next_grant: got %b expected 01", g2); else passed++;
        ahs2 = 1'b1; cyc(); ahs2 = 1'b0;
        req2 = 2'b00;
        rhs2 = 1'b1; cyc(); rhs2 = 1'b0;
    endtask

    task automatic test_mid_reset();
        req2 = 2'b11;
        cyc();
        checks++; if (g2 !== 2'b10) $display("FAIL midrst_pre_grant: got %b expected 10", g2); else passed++;
        ahs2 = 1'b1; cyc(); ahs2 = 1'b0;
        rst_n = 1'b0;
        cyc();
        checks++; if (g2 !== 2'b00) $display("FAIL midrst_grant: got %b expected 00", g2); else passed++;
        checks++; if (busy2 !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy2); else passed++;
        rst_n = 1'b1;
        cyc();
        checks++; if (g2 !== 2'b01) $display("FAIL midrst_ptr_reset: got %b expected 01", g2); else passed++;
        ahs2 = 1'b1; cyc(); ahs2 = 1'b0;
        req2 = 2'b00;
        rhs2 = 1'b1; cyc(); rhs2 = 1'b0;
    endtask

    task automatic test_rotation();
        int exp_idx [6] = '{0, 1, 2, 0, 1, 2};
        logic [2:0] exp_g;
        req3 = 3'b111;
        for (int t = 0; t < 6; t++) begin
            exp_g = 3'b001 << exp_idx[t];
            cyc();
            checks++; if (g3 !== exp_g) $display("FAIL rot_grant%0d: got %b expected %b", t, g3, exp_g); else passed++;
            checks++; if (gi3 !== 2'(exp_idx[t])) $display("FAIL rot_idx%0d: got %0d expected %0d", t, gi3, exp_idx[t]); else passed++;
            ahs3 = 1'b1; cyc(); ahs3 = 1'b0;
            rhs3 = 1'b1; cyc(); rhs3 = 1'b0;
            checks++; if (g3 !== 3'b000) $display("FAIL rot_gap%0d: got %b expected 000", t, g3); else passed++;
        end
        req3 = 3'b000;
        cyc();
        checks++; if (busy3 !== 1'b0) $display("FAIL rot_no_req_busy: got %b expected 0", busy3); else passed++;
    endtask

    task automatic test_skip();
        req4 = 4'b0001;
        cyc();
        checks++; if (g4 !== 4'b0001) $display("FAIL skip_first: got %b expected 0001", g4); else passed++;
        ahs4 = 1'b1; cyc(); ahs4 = 1'b0;
        req4 = 4'b0000;
        rhs4 = 1'b1; cyc(); rhs4 = 1'b0;
        req4 = 4'b1001;
        cyc();
        checks++; if (gi4 !== 2'd3) $display("FAIL skip_idx: got %0d expected 3", gi4); else passed++;
        checks++; if (g4 !== 4'b1000) $display("FAIL skip_grant: got %b expected 1000", g4); else passed++;
        ahs4 = 1'b1; cyc(); ahs4 = 1'b0;
        req4 = 4'b0001;
        rhs4 = 1'b1; cyc(); rhs4 = 1'b0;
        cyc();
        checks++; if (g4 !== 4'b0001) $display("FAIL skip_wrap_grant: got %b expected 0001", g4); else passed++;
        checks++; if (gi4 !== 2'd0) $display("FAIL skip_wrap_idx: got %0d expected 0", gi4); else passed++;
        ahs4 = 1'b1; cyc(); ahs4 = 1'b0;
        req4 = 4'b0000;
        rhs4 = 1'b1; cyc(); rhs4 = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        n    = 0;
        req3 = 3'b011;
        cyc();
        checks++; if (g3 !== 3'b001) $display("FAIL to_grant: got %b expected 001", g3); else passed++;
        ahs3 = 1'b1; cyc(); ahs3 = 1'b0;
        n = 1;
`ifdef AXI_ARB_TIMEOUT_EN
        while (n < 30 && to3 !== 1'b1) begin
            cyc();
            n++;
        end
        checks++; if (n !== 9) $display("FAIL to_pulse_cycle: got %0d expected 9", n); else passed++;
        checks++; if (g3 !== 3'b000) $display("FAIL to_grant_drop: got %b expected 000", g3); else passed++;
        cyc();
        checks++; if (to3 !== 1'b0) $display("FAIL to_pulse_width: got %b expected 0", to3); else passed++;
        checks++; if (g3 !== 3'b010) $display("FAIL to_next_grant: got %b expected 010", g3); else passed++;
        ahs3 = 1'b1; cyc(); ahs3 = 1'b0;
        repeat (7) cyc();
        checks++; if (to3 !== 1'b0) $display("FAIL to_early: got %b expected 0", to3); else passed++;
        rhs3 = 1'b1; cyc(); rhs3 = 1'b0;
        checks++; if (to3 !== 1'b0) $display("FAIL to_hs_wins: got %b expected 0", to3); else passed++;
        checks++; if (g3 !== 3'b000) $display("FAIL to_hs_grant: got %b expected 000", g3); else passed++;
        cyc();
        checks++; if (to3 !== 1'b0) $display("FAIL to_hs_after: got %b expected 0", to3); else passed++;
        checks++; if (g3 !== 3'b001) $display("FAIL to_wrap_grant: got %b expected 001", g3); else passed++;
`else
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (to3 !== 1'b0) n = 100;
        end
        checks++; if (n !== 1) $display("FAIL no_to_pulse: got %0d expected 1", n); else passed++;
        checks++; if (g3 !== 3'b001) $display("FAIL no_to_hold: got %b expected 001", g3); else passed++;
        req3 = 3'b000;
        rhs3 = 1'b1; cyc(); rhs3 = 1'b0;
        checks++; if (g3 !== 3'b000) $display("FAIL no_to_release: got %b expected 000", g3); else passed++;
`endif
        req3 = 3'b000;
        if (busy3) begin
            ahs3 = 1'b1; cyc(); ahs3 = 1'b0;
            rhs3 = 1'b1; cyc(); rhs3 = 1'b0;
        end
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        req2 = '0; ahs2 = 1'b0; rhs2 = 1'b0;
        req3 = '0; ahs3 = 1'b0; rhs3 = 1'b0;
        req4 = '0; ahs4 = 1'b0; rhs4 = 1'b0;
        cyc();
        test_reset();
        test_hold();
        test_mid_reset();
        test_rotation();
        test_skip();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
